// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/ISSUE/EXEC sequencer that owns the shrv32 program counter.
// Optional feature: define MISALIGN_TRAP_EN to redirect misaligned next PCs to TRAP_VEC.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        ex_done,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_target,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap,
  output logic [31:0] trap_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2
  } state_t;

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t      state_r;
  state_t      state_next_s;
  logic        in_reset_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] instret_r;
  logic [31:0] trap_pc_r;
  logic        retire_r;
  logic        trap_r;

  logic        fetch_ack_s;
  logic        commit_s;
  logic        taken_s;
  logic [31:0] raw_next_s;
  logic [31:0] commit_pc_s;
  logic        commit_trap_s;

  // Direct magnitude compares on the raw operands, no subtractor sign bit involved.
  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign fetch_ack_s = (state_r == FETCH) && imem_ack && !in_reset_r;
  assign commit_s    = (state_r == EXEC) && ex_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH: begin
        if (fetch_ack_s) state_next_s = ISSUE;
        else             state_next_s = FETCH;
      end
      ISSUE: state_next_s = EXEC;
      EXEC: begin
        if (ex_done) state_next_s = FETCH;
        else         state_next_s = EXEC;
      end
      default: state_next_s = FETCH;
    endcase
  end

  // Next-PC resolution; jump outranks branch.
  always_comb begin
    taken_s = branch_taken(ex_funct3, ex_rs1, ex_rs2);
    if (ex_is_jump) begin
      raw_next_s = ex_target;
    end else if (ex_is_branch && taken_s) begin
      raw_next_s = ex_target;
    end else begin
      raw_next_s = pc_r + 32'd4;
    end
    if (TRAP_EN && (raw_next_s[1:0] != 2'b00)) begin
      commit_pc_s   = TRAP_VEC;
      commit_trap_s = 1'b1;
    end else begin
      commit_pc_s   = {raw_next_s[31:2], 2'b00};
      commit_trap_s = 1'b0;
    end
  end

  // Datapath registers and the one-cycle commit flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_reset_r <= 1'b1;
      pc_r       <= RESET_PC;
      inst_r     <= 32'd0;
      instret_r  <= 32'd0;
      trap_pc_r  <= 32'd0;
      retire_r   <= 1'b0;
      trap_r     <= 1'b0;
    end else begin
      in_reset_r <= 1'b0;
      retire_r   <= commit_s;
      trap_r     <= commit_s && commit_trap_s;
      if (fetch_ack_s) begin
        inst_r <= imem_rdata;
      end
      if (commit_s) begin
        pc_r      <= commit_pc_s;
        instret_r <= instret_r + 32'd1;
        if (commit_trap_s) begin
          trap_pc_r <= raw_next_s;
        end
      end
    end
  end

  // Outputs decoded purely from registered state; in_reset_r masks the reset cycle.
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state_r)
      FETCH:   imem_req   = !in_reset_r;
      ISSUE:   inst_valid = !in_reset_r;
      EXEC:    imem_req   = 1'b0;
      default: imem_req   = 1'b0;
    endcase
  end

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign inst      = inst_r;
  assign instret   = instret_r;
  assign retire    = retire_r;
  assign trap      = trap_r;
  assign trap_pc   = trap_pc_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, multi-cycle corners, randomized model check.
// Honours MISALIGN_TRAP_EN when expecting trap behaviour.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        ex_done = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jump = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_rs1 = 32'd0;
  logic [31:0] ex_rs2 = 32'd0;
  logic [31:0] ex_target = 32'd0;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        trap;
  logic [31:0] trap_pc;

  pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid),
    .ex_done(ex_done), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_target(ex_target),
    .pc(pc), .retire(retire), .instret(instret), .trap(trap), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_instret = 32'd0;
  logic [31:0] m_trap_pc = 32'd0;

  typedef struct {
    logic [2:0]  f3;
    logic        br;
    logic        jmp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference branch rule: signed order obtained by biasing into unsigned order.
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bias;
    bias = 32'h8000_0000;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return (a ^ bias) < (b ^ bias);
      3'd5: return (a ^ bias) >= (b ^ bias);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drives one full instruction starting in FETCH and checks every phase.
  task automatic run_instr(input int ack_wait, input int ex_wait, input logic br, input logic jmp,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] t, input logic [31:0] rdata, input logic [31:0] exp_raw);
    logic        exp_trap;
    logic [31:0] exp_pc;
`ifdef MISALIGN_TRAP_EN
    exp_trap = (exp_raw % 32'd4) != 32'd0;
    exp_pc   = exp_trap ? TRAP_VEC : exp_raw;
    if (exp_trap) m_trap_pc = exp_raw;
`else
    exp_trap = 1'b0;
    exp_pc   = exp_raw - (exp_raw % 32'd4);
`endif
    chk("fetch_req", imem_req, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("pc_out", pc, m_pc);
    for (int i = 0; i < ack_wait; i++) begin
      ex_done = 1'b1;
      imem_ack = 1'b0;
      tick();
      chk("stall_req", imem_req, 32'd1);
      chk("stall_addr", imem_addr, m_pc);
      chk("stall_valid", inst_valid, 32'd0);
      chk("stall_retire", retire, 32'd0);
    end
    ex_done = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("issue_valid", inst_valid, 32'd1);
    chk("issue_inst", inst, rdata);
    chk("issue_req", imem_req, 32'd0);
    chk("issue_retire", retire, 32'd0);
    ex_is_branch = br;
    ex_is_jump = jmp;
    ex_funct3 = f3;
    ex_rs1 = a;
    ex_rs2 = b;
    ex_target = t;
    ex_done = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("exec_valid", inst_valid, 32'd0);
    chk("exec_req", imem_req, 32'd0);
    chk("exec_inst_hold", inst, rdata);
    chk("exec_retire", retire, 32'd0);
    for (int i = 0; i < ex_wait; i++) begin
      ex_done = 1'b0;
      tick();
      chk("exwait_retire", retire, 32'd0);
      chk("exwait_pc", pc, m_pc);
    end
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    m_instret = m_instret + 32'd1;
    m_pc = exp_pc;
    chk("retire", retire, 32'd1);
    chk("trap", trap, {31'd0, exp_trap});
    chk("trap_pc", trap_pc, m_trap_pc);
    chk("instret", instret, m_instret);
    chk("next_pc", pc, m_pc);
    chk("next_addr", imem_addr, m_pc);
    chk("next_req", imem_req, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic br;
    logic jmp;
    logic [2:0] f3;
    logic [31:0] a, b, t, raw;

    vecs[0]  = '{3'd0, 1'b0, 1'b1, 32'd0,          32'd0,          32'h0000_0040, 1'b1};
    vecs[1]  = '{3'd4, 1'b1, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0080, 1'b1};
    vecs[2]  = '{3'd0, 1'b0, 1'b1, 32'd0,          32'd0,          32'h0000_0040, 1'b1};
    vecs[3]  = '{3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0080, 1'b0};
    vecs[4]  = '{3'd5, 1'b1, 1'b0, 32'h8000_0000,  32'h8000_0000,  32'h0000_0200, 1'b1};
    vecs[5]  = '{3'd7, 1'b1, 1'b0, 32'd0,          32'h8000_0000,  32'h0000_0300, 1'b0};
    vecs[6]  = '{3'd0, 1'b1, 1'b0, 32'd5,          32'd5,          32'h0000_0400, 1'b1};
    vecs[7]  = '{3'd1, 1'b1, 1'b0, 32'd5,          32'd5,          32'h0000_0500, 1'b0};
    vecs[8]  = '{3'd2, 1'b1, 1'b0, 32'd1,          32'd2,          32'h0000_0600, 1'b0};
    vecs[9]  = '{3'd3, 1'b1, 1'b0, 32'd1,          32'd2,          32'h0000_0600, 1'b0};
    vecs[10] = '{3'd0, 1'b0, 1'b0, 32'd7,          32'd7,          32'h0000_0700, 1'b0};
    vecs[11] = '{3'd1, 1'b1, 1'b1, 32'd5,          32'd5,          32'h0000_0800, 1'b1};

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req", imem_req, 32'd0);
    chk("rst_valid", inst_valid, 32'd0);
    chk("rst_retire", retire, 32'd0);
    chk("rst_trap", trap, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_req", imem_req, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);

    // Three back-to-back sequential instructions at minimum latency.
    for (int i = 0; i < 3; i++) begin
      run_instr(0, 0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'h1000_0000 + i, m_pc + 32'd4);
    end
    chk("instret_three", instret, 32'd3);
    chk("pc_after_three", pc, 32'h0000_000C);

    // Directed branch/jump table with hand-derived outcomes.
    for (int i = 0; i < 12; i++) begin
      raw = vecs[i].exp_taken ? vecs[i].t : m_pc + 32'd4;
      run_instr(0, 0, vecs[i].br, vecs[i].jmp, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].t,
                32'hA000_0000 + i, raw);
    end

    // Slow memory and slow execute: stray ex_done during FETCH stalls.
    run_instr(5, 2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'hBEEF_0001, m_pc + 32'd4);

    // Misaligned jump target.
    run_instr(0, 0, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 32'h0000_0102, 32'hBEEF_0002, 32'h0000_0102);
    chk("misalign_fetch", imem_addr, 32'h0000_0100);

    // Reset while in EXEC with ex_done high.
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    rst = 1'b1;
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    chk("midrst_retire", retire, 32'd0);
    chk("midrst_instret", instret, 32'd0);
    chk("midrst_req", imem_req, 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_retire2", retire, 32'd0);
    chk("midrst_addr", imem_addr, RESET_PC);
    chk("midrst_req2", imem_req, 32'd1);
    chk("midrst_instret2", instret, 32'd0);
    m_pc = RESET_PC;
    m_instret = 32'd0;
    m_trap_pc = 32'd0;

    // Randomized instructions against the reference rules.
    for (int i = 0; i < 40; i++) begin
      br  = 1'($urandom % 2);
      jmp = (($urandom % 4) == 0);
      f3  = 3'($urandom);
      a   = $urandom;
      b   = (($urandom % 3) == 0) ? a : $urandom;
      t   = $urandom;
      if (jmp) raw = t;
      else if (br && ref_taken(f3, a, b)) raw = t;
      else raw = m_pc + 32'd4;
      run_instr(int'($urandom % 3), int'($urandom % 3), br, jmp, f3, a, b, t, $urandom, raw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
